// File: rtl/beta_pkg.sv
// Shared Beta definitions: exception vectors, privilege bit, icache FSM states
// and the width helpers the cache uses to split an address.
package beta_pkg;

  localparam logic [31:0] RESET = 32'h8000_0000;
  localparam logic [31:0] ILLOP = 32'h8000_0004;
  localparam logic [31:0] XADR  = 32'h8000_0008;

  localparam int SUPERVISOR_BIT = 31;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } icache_state_e;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Bits [30 : 2+OFF_W+IDX_W]; the supervisor bit never takes part in the tag.
  function automatic int tag_w(input int lines, input int words);
    return 29 - off_w(words) - idx_w(lines);
  endfunction

  localparam int OFF_W = off_w(4);
  localparam int IDX_W = idx_w(16);
  localparam int TAG_W = tag_w(16, 4);

endpackage

// File: rtl/beta_icache_array.sv
// Valid/tag/data storage for beta_icache: combinational read, one write port,
// line set/invalidate and a bulk clear of every valid bit.
module beta_icache_array
  import beta_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int OFFW  = off_w(WORDS),
  parameter int IDXW  = idx_w(LINES),
  parameter int TAGW  = tag_w(LINES, WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] rd_idx,
  input  logic [OFFW-1:0] rd_off,
  output logic            rd_valid,
  output logic [TAGW-1:0] rd_tag,
  output logic [31:0]     rd_data,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [OFFW-1:0] wr_off,
  input  logic [31:0]     wr_data,
  input  logic            wr_en,
  input  logic            set_en,
  input  logic [TAGW-1:0] set_tag,
  input  logic            inval_en,
  input  logic            clear_all
);

  logic [LINES-1:0] valid;
  logic [TAGW-1:0]  tags [LINES];
  logic [31:0]      data [LINES][WORDS];

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      valid <= '0;
    end else if (set_en) begin
      valid[wr_idx] <= 1'b1;
    end else if (inval_en) begin
      valid[wr_idx] <= 1'b0;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bit alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (set_en) begin
      tags[wr_idx] <= set_tag;
    end
    if (wr_en) begin
      data[wr_idx][wr_off] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx][rd_off];

endmodule

// File: rtl/beta_icache.sv
// beta_icache: direct-mapped read-only instruction cache for the Beta core.
// Hits answer in the same cycle; misses fill a whole line over a one-outstanding bus.
module beta_icache
  import beta_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  output logic [31:0] cpu_data,
  output logic        cpu_ready,
  output logic        cpu_fault,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_data,
  input  logic        mem_ack,
  input  logic        mem_fault
);

  localparam int OFFW    = off_w(WORDS);
  localparam int IDXW    = idx_w(LINES);
  localparam int TAGW    = tag_w(LINES, WORDS);
  localparam int TAG_LSB = 2 + OFFW + IDXW;
  localparam logic [OFFW-1:0] LAST_WORD = OFFW'(WORDS - 1);

  icache_state_e   state;
  logic [IDXW-1:0] fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic [OFFW-1:0] word_cnt;
  logic            fault_latch;
  logic            flush_pending;

  logic [OFFW-1:0] req_off;
  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic            unused_addr_bits;

  logic            line_valid;
  logic [TAGW-1:0] line_tag;
  logic [31:0]     line_data;

  logic            lookup_en, hit, fault_resp, miss_start;
  logic            fill_ack, last_word, fill_end, flush_now;
  logic [IDXW-1:0] wr_idx;

  assign req_off          = cpu_addr[2 +: OFFW];
  assign req_idx          = cpu_addr[2 + OFFW +: IDXW];
  assign req_tag          = cpu_addr[SUPERVISOR_BIT-1 : TAG_LSB];
  assign unused_addr_bits = ^{cpu_addr[SUPERVISOR_BIT], cpu_addr[1:0]};

  // A non-faulting RESP cycle looks up the current address exactly like IDLE.
  assign lookup_en  = (state == IDLE) || (state == RESP && !fault_latch);
  assign hit        = lookup_en && line_valid && (line_tag == req_tag) && !rst && !flush;
  assign fault_resp = (state == RESP) && fault_latch && !rst;
  assign miss_start = (state == IDLE) && !hit && !flush && !rst;

  assign fill_ack  = (state == FILL) && mem_ack && !rst;
  assign last_word = (word_cnt == LAST_WORD);
  assign fill_end  = fill_ack && (mem_fault || last_word);
  assign flush_now = flush || flush_pending;
  assign wr_idx    = (state == FILL) ? fill_idx : req_idx;

  assign cpu_ready = hit || fault_resp;
  assign cpu_fault = fault_resp;
  assign cpu_data  = hit ? line_data : 32'h0;

  assign mem_req   = (state == FILL) && !rst;
  assign mem_addr  = {1'b0, fill_tag, fill_idx, word_cnt, 2'b00};

  beta_icache_array #(
    .LINES(LINES),
    .WORDS(WORDS),
    .OFFW (OFFW),
    .IDXW (IDXW),
    .TAGW (TAGW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_idx),
    .rd_off   (req_off),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_idx   (wr_idx),
    .wr_off   (word_cnt),
    .wr_data  (mem_data),
    .wr_en    (fill_ack && !mem_fault),
    .set_en   (fill_end && !mem_fault && !flush_now),
    .set_tag  (fill_tag),
    .inval_en (miss_start),
    .clear_all((flush && state != FILL) || (fill_end && flush_now))
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      word_cnt      <= '0;
      fault_latch   <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_start) begin
            fill_idx <= req_idx;
            fill_tag <= req_tag;
            word_cnt <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (fill_end) begin
            state         <= RESP;
            word_cnt      <= '0;
            fault_latch   <= mem_fault;
            flush_pending <= 1'b0;
          end else begin
            if (fill_ack) begin
              word_cnt <= word_cnt + 1'b1;
            end
            if (flush) begin
              flush_pending <= 1'b1;
            end
          end
        end
        RESP: begin
          state       <= IDLE;
          fault_latch <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_icache.sv
// Self-checking bench for beta_icache: a line-level cache/bus model is compared
// with the DUT every cycle, with directed scenarios pinned by literal expectations.
module tb_beta_icache;

  localparam int LINES      = 16;
  localparam int WORDS      = 4;
  localparam int LINE_BYTES = 4 * WORDS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_data;
  logic        cpu_ready, cpu_fault;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_data = 32'h0;
  logic        mem_ack = 1'b0;
  logic        mem_fault = 1'b0;

  always #5 clk = ~clk;

  beta_icache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_ready(cpu_ready),
    .cpu_fault(cpu_fault),
    .flush    (flush),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .mem_fault(mem_fault)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: which line base each slot holds, plus progress of the fill in flight.
  bit          m_valid [LINES];
  logic [31:0] m_base  [LINES];
  bit          m_fill, m_resp, m_resp_fault, m_pend;
  int          m_got;
  logic [31:0] m_fill_base;

  int unsigned ack_pct    = 100;
  int unsigned fault_pct  = 0;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;

  logic        obs_ready, obs_fault, obs_req;
  logic [31:0] obs_addr;
  logic [31:0] req_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'h7FFF_FFFF & ~32'(LINE_BYTES - 1);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(((a & 32'h7FFF_FFFF) / LINE_BYTES) % LINES);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // One clock cycle: answer the bus, compare all outputs, advance the model.
  task automatic tick();
    logic [31:0] e_addr;
    bit          e_req, lookup, e_hit, e_fresp;
    int          e_idx;
    e_addr    = m_fill_base + 32'(4 * m_got);
    e_req     = !rst && m_fill;
    mem_ack   = e_req && ($urandom_range(99) < ack_pct);
    mem_fault = mem_ack && (e_addr == fault_addr || $urandom_range(99) < fault_pct);
    mem_data  = mem_ack ? mem_word(e_addr) : $urandom;
    #3;
    e_idx   = idx_of(cpu_addr);
    lookup  = !rst && !flush && ((!m_fill && !m_resp) || (m_resp && !m_resp_fault));
    e_hit   = lookup && m_valid[e_idx] && (m_base[e_idx] == line_of(cpu_addr));
    e_fresp = !rst && m_resp && m_resp_fault;
    check("cpu_ready", 32'(cpu_ready), 32'(e_hit || e_fresp));
    check("cpu_fault", 32'(cpu_fault), 32'(e_fresp));
    check("cpu_data", cpu_data, e_hit ? mem_word(cpu_addr & 32'h7FFF_FFFC) : 32'h0);
    check("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) check("mem_addr", mem_addr, e_addr);
    obs_ready = cpu_ready;
    obs_fault = cpu_fault;
    obs_req   = mem_req;
    obs_addr  = mem_addr;

    if (rst) begin
      clear_model();
      m_fill = 0; m_resp = 0; m_resp_fault = 0; m_pend = 0; m_got = 0;
    end else if (m_fill) begin
      if (flush) m_pend = 1;
      if (mem_ack) begin
        if (mem_fault) begin
          m_fill = 0; m_resp = 1; m_resp_fault = 1;
        end else begin
          m_got++;
          if (m_got == WORDS) begin
            m_fill = 0; m_resp = 1; m_resp_fault = 0;
            if (!m_pend) begin
              m_valid[idx_of(m_fill_base)] = 1;
              m_base[idx_of(m_fill_base)]  = m_fill_base;
            end
          end
        end
        if (!m_fill) begin
          if (m_pend) clear_model();
          m_pend = 0;
          m_got  = 0;
        end
      end
    end else if (m_resp) begin
      m_resp = 0; m_resp_fault = 0;
      if (flush) clear_model();
    end else if (flush) begin
      clear_model();
    end else if (!e_hit) begin
      m_fill = 1; m_got = 0;
      m_fill_base = line_of(cpu_addr);
      m_valid[e_idx] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_ready(input int max_ticks, output int lat);
    lat = -1;
    req_log.delete();
    for (int i = 0; i < max_ticks; i++) begin
      tick();
      if (obs_req) req_log.push_back(obs_addr);
      if (obs_ready) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: no cpu_ready within %0d cycles for addr %h", max_ticks, cpu_addr);
    end
  endtask

  initial begin
    int lat;
    int hold;
    logic [31:0] a;

    clear_model();
    m_fill = 0; m_resp = 0; m_resp_fault = 0; m_pend = 0; m_got = 0; m_fill_base = 0;

    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(obs_ready), 32'h0);
    check("rst_req", 32'(obs_req), 32'h0);
    rst = 1'b0;

    // Cold miss at 0x0 with single-cycle acks.
    cpu_addr = 32'h0000_0000;
    run_until_ready(50, lat);
    check("cold_latency", 32'(lat), 32'd5);
    check("cold_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < req_log.size() && i < 4; i++) check("cold_addr", req_log[i], 32'(4 * i));
    cpu_addr = 32'h0000_0004;
    tick();
    check("warm_hit", 32'(obs_ready), 32'h1);
    check("warm_noreq", 32'(obs_req), 32'h0);

    // Supervisor bit does not split the line.
    cpu_addr = 32'h0000_0040;
    run_until_ready(50, lat);
    cpu_addr = 32'h8000_0044;
    tick();
    check("super_hit", 32'(obs_ready), 32'h1);
    check("super_noreq", 32'(obs_req), 32'h0);

    // Conflict eviction on index 0.
    cpu_addr = 32'h0000_0100;
    run_until_ready(50, lat);
    check("conflict_latency", 32'(lat), 32'd5);
    cpu_addr = 32'h0000_0000;
    run_until_ready(50, lat);
    check("evicted_latency", 32'(lat), 32'd5);

    // Bus fault on the second word, then a successful retry.
    fault_addr = 32'h0000_0204;
    cpu_addr   = 32'h0000_0200;
    run_until_ready(50, lat);
    check("fault_latency", 32'(lat), 32'd3);
    check("fault_flag", 32'(obs_fault), 32'h1);
    fault_addr = 32'hFFFF_FFFF;
    tick();
    check("fault_not_cached", 32'(obs_ready), 32'h0);
    tick();
    check("retry_req", 32'(obs_req), 32'h1);
    check("retry_addr", obs_addr, 32'h0000_0200);
    run_until_ready(50, lat);
    check("retry_latency", 32'(lat), 32'd3);
    check("retry_nofault", 32'(obs_fault), 32'h0);

    // Flush during the third word of a fill.
    cpu_addr = 32'h0000_0300;
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    cpu_addr = 32'h0000_0040;
    tick();
    check("flush_resp_miss", 32'(obs_ready), 32'h0);
    run_until_ready(50, lat);
    check("flush_old_latency", 32'(lat), 32'd5);
    cpu_addr = 32'h0000_0300;
    run_until_ready(50, lat);
    check("flush_fill_latency", 32'(lat), 32'd5);

    // Reset in the middle of a stalled fill.
    ack_pct  = 0;
    cpu_addr = 32'h0000_0500;
    tick();
    tick();
    check("stall_req", 32'(obs_req), 32'h1);
    rst = 1'b1;
    tick();
    check("rst_drop_req", 32'(obs_req), 32'h0);
    rst = 1'b0;
    cpu_addr = 32'h0000_0040;
    tick();
    check("post_rst_miss", 32'(obs_ready), 32'h0);
    check("post_rst_idle", 32'(obs_req), 32'h0);
    ack_pct = 100;
    run_until_ready(50, lat);
    check("post_rst_latency", 32'(lat), 32'd4);

    // Randomised traffic: stalls, faults, flushes, resets and address churn.
    ack_pct   = 60;
    fault_pct = 5;
    for (int n = 0; n < 600; n++) begin
      a = ($urandom_range(2) << 8) | ($urandom_range(15) << 4) | 32'($urandom_range(15));
      if ($urandom_range(1) == 1) a = a | 32'h8000_0000;
      cpu_addr = a;
      hold = int'($urandom_range(8, 1));
      for (int h = 0; h < hold; h++) begin
        flush = ($urandom_range(63) == 0);
        rst   = ($urandom_range(399) == 0);
        tick();
      end
    end
    flush = 1'b0;
    rst   = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/beta_icache.md
Name: beta_icache

Overview:
- Direct-mapped, read-only instruction cache between the Beta core's instruction port and the shared main-memory bus.
- Serves InstructionData and instructionReady (with a fault flag) to the core on a hit in the same cycle the address is presented.
- On a miss, a fill FSM fetches the whole line over a one-outstanding-request bus handshake.

Parameters:
- LINES, 16, number of cache lines; power of 2, minimum 2.
- WORDS, 4, 32-bit words per line; power of 2, minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- cpu_addr  input  32  byte address from the core; bit 31 is the supervisor flag; bits [1:0] ignored.
- cpu_data  output  32  instruction word; valid when cpu_ready=1.
- cpu_ready  output  1  cpu_data (or cpu_fault) valid this cycle.
- cpu_fault  output  1  instruction fetch fault; only meaningful when cpu_ready=1.
- flush  input  1  invalidate all lines.
- mem_addr  output  32  word-aligned fill address; bit 31 and bits [1:0] forced to 0.
- mem_req  output  1  fill request; held until acknowledged.
- mem_data  input  32  fill data; valid when mem_ack=1.
- mem_ack  input  1  request accepted and data returned this cycle.
- mem_fault  input  1  bus error on this access; qualified by mem_ack.

Behaviour:
- Address split:
  - off = cpu_addr[2 +: log2(WORDS)]
  - idx = next log2(LINES) bits
  - tag = bits [30 : 2+log2(WORDS)+log2(LINES)]
  - Bit 31 is excluded from the tag: user and supervisor fetches of the same address hit the same line.
- Storage: per-line valid bit and tag, plus data array, all in flops. Read is combinational from cpu_addr.
- Hit = state==IDLE && valid[idx] && tag matches && !rst && !flush.
  - On a hit: cpu_ready=1, cpu_fault=0, cpu_data=data[idx][off], same cycle, zero latency.
- FSM states IDLE, FILL, RESP.
  - IDLE, miss (not hit, not flush): latch line base (idx, tag); word counter=0; go to FILL.
  - FILL:
    - mem_req=1; mem_addr = line base + 4*counter.
    - On mem_ack with !mem_fault: write mem_data into data[idx][counter]; counter++.
    - After the last word: set valid[idx] and tag[idx], go to RESP.
    - On mem_ack with mem_fault: abort fill, leave valid[idx]=0, set fault_latch, go to RESP.
  - RESP (one cycle):
    - If fault_latch: cpu_ready=1, cpu_fault=1, cpu_data=0.
    - Otherwise behave as IDLE: re-evaluate the hit against the current cpu_addr.
    - Always return to IDLE next cycle and clear fault_latch.
- Outside a hit or the RESP fault cycle, cpu_ready=0, cpu_fault=0 and cpu_data=0.
- Words are fetched in order 0..WORDS-1. There is no critical-word-first and no early restart.
- The miss penalty with a 1-cycle ack is WORDS+1 cycles from miss to hit.
- cpu_addr changes during FILL (branch or stall change): the fill always completes for the latched line. The new address is evaluated in RESP/IDLE. No abort.
- mem_req must not drop between words of one fill unless mem_ack was seen for the last word or a fault occurred.
  - mem_addr is stable while mem_req=1 and not acked.
- flush:
  - In IDLE: clear all valid bits at the clock edge; cpu_ready=0 that cycle.
  - In FILL: set flush_pending. The fill completes, then the line is not marked valid and all valid bits are cleared on the transition to RESP.
  - flush and a fill completion in the same cycle are handled by that same rule: flush wins.
- Reset: all valid=0, state=IDLE, counter=0, fault_latch=0, flush_pending=0.
  - mem_req=0 and cpu_ready=0 while rst=1.
  - Reset mid-FILL abandons the request; the bus must tolerate a dropped mem_req.
- Faulted lines are never cached. A refetch of a faulted address retries the bus.

Decomposition:
- Shared package (beta_pkg):
  - Constants RESET/ILLOP/XADR vectors.
  - SUPERVISOR_BIT=31.
  - icache state enum (IDLE, FILL, RESP).
  - Derived widths OFF_W=log2(WORDS), IDX_W=log2(LINES), TAG_W=29-OFF_W-IDX_W.
- One natural sub-module: beta_icache_array (valid/tag/data storage, combinational read, single write port, bulk valid clear).

Test Plan:
- Cold miss at 0x00000000, mem_ack one cycle after each mem_req -> mem_addr 0x0,0x4,0x8,0xC requested in order; cpu_ready=1 with the word at 0x0 exactly 5 cycles after the miss; a next fetch of 0x4 hits in 0 cycles.
- Line fill at 0x00000040, then fetch 0x80000044 -> hit (bit 31 ignored); mem_req stays 0.
- Fetch 0x00000100 (same idx as 0x0, different tag) after 0x0 is cached -> miss and refill; a later fetch of 0x0 misses again.
- mem_fault with mem_ack on the second word of a fill at 0x200 -> one cycle of cpu_ready=1, cpu_fault=1; valid[idx] stays 0; a retry of 0x200 issues mem_req to 0x200 again.
- Assert flush during the third word of a fill at 0x300 -> fill completes; a fetch of 0x300 and of a previously cached 0x0 both miss.
- Assert rst mid-FILL with mem_ack held low -> mem_req=0 next cycle; all previously cached addresses miss after reset deasserts.
